// File: rtl/pre_decode_pkg.sv
// Shared constants and entry layout for the pre-decode issue buffer.
// Optional feature macro used by the top: PRE_DECODE_PERF_CNT_EN.
package pre_decode_pkg;
   // primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BLEZ    = 6'b000110;
   localparam logic [5:0] OP_BGTZ    = 6'b000111;
   localparam logic [5:0] OP_COP0    = 6'b010000;

   // function codes (instr[5:0])
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_JALR    = 6'b001001;
   localparam logic [5:0] FN_SYSCALL = 6'b001100;
   localparam logic [5:0] FN_BREAK   = 6'b001101;
   localparam logic [5:0] FN_ERET    = 6'b011000;
   localparam logic [5:0] FN_MFHI    = 6'b010000;
   localparam logic [5:0] FN_MTHI    = 6'b010001;
   localparam logic [5:0] FN_MFLO    = 6'b010010;
   localparam logic [5:0] FN_MTLO    = 6'b010011;
   localparam logic [5:0] FN_MULT    = 6'b011000;
   localparam logic [5:0] FN_MULTU   = 6'b011001;
   localparam logic [5:0] FN_DIV     = 6'b011010;
   localparam logic [5:0] FN_DIVU    = 6'b011011;

   // class vector bit positions: {nop, hilo, trap_priv, branch}
   localparam int CLS_BRANCH = 0;
   localparam int CLS_TRAP   = 1;
   localparam int CLS_HILO   = 2;
   localparam int CLS_NOP    = 3;

   // one buffered instruction with its write-time decode
   typedef struct packed {
      logic [31:0] instr;
      logic [3:0]  cls;
      logic [4:0]  dest;
   } entry_t;
endpackage

// File: rtl/pre_decode_slot.sv
// Combinational classifier for one fetched instruction: class bits and
// destination register, computed once when the entry is written.
module pre_decode_slot
   import pre_decode_pkg::*;
(
   input  logic [31:0] instr,
   output logic [3:0]  cls,
   output logic [4:0]  dest
);
   logic [5:0] op, fn;
   logic [4:0] rs, rt, rd;

   assign op = instr[31:26];
   assign rs = instr[25:21];
   assign rt = instr[20:16];
   assign rd = instr[15:11];
   assign fn = instr[5:0];

   // decode class and destination from opcode/func fields
   always_comb begin
      cls  = '0;
      dest = '0;
      if (op == OP_SPECIAL) begin
         cls[CLS_BRANCH] = (fn == FN_JR) || (fn == FN_JALR);
         cls[CLS_TRAP]   = (fn == FN_SYSCALL) || (fn == FN_BREAK);
         cls[CLS_HILO]   = (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
         dest            = rd;
      end
      if (op inside {OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ})
         cls[CLS_BRANCH] = 1'b1;
      if (op == OP_COP0)
         cls[CLS_TRAP] = (fn == FN_ERET) || (rs == 5'd0) || (rs == 5'd4);
      if (op == OP_JAL)
         dest = 5'd31;
      // immediate ALU ops (001xxx) and loads (100xxx) write rt
      if ((op[5:3] == 3'b001) || (op[5:3] == 3'b100))
         dest = rt;
      cls[CLS_NOP] = (instr == 32'd0);
   end
endmodule

// File: rtl/pre_decode_issue_buffer.sv
// Circular fetch->issue buffer: 2-wide write with decode, presents the two
// oldest entries with registered valid/dual-issue flags. Branches are held
// back until their delay slot is buffered and then always dual-issue.
// Optional: define PRE_DECODE_PERF_CNT_EN for single/dual issue counters.
module pre_decode_issue_buffer
   import pre_decode_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int PC_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [1:0]          in_valid,
   input  logic [31:0]         in_instr0,
   input  logic [31:0]         in_instr1,
   input  logic [PC_WIDTH-1:0] in_pc0,
   input  logic [PC_WIDTH-1:0] in_pc1,
   output logic                in_ready,
   output logic [1:0]          out_valid,
   output logic [31:0]         out_instr0,
   output logic [31:0]         out_instr1,
   output logic [PC_WIDTH-1:0] out_pc0,
   output logic [PC_WIDTH-1:0] out_pc1,
   output logic [3:0]          out_class0,
   output logic [3:0]          out_class1,
   output logic                dual_ok,
   input  logic [1:0]          issue_ack,
   output logic [31:0]         perf_single,
   output logic [31:0]         perf_dual
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] RDY_MAX = (AW+1)'(DEPTH - 2);

   entry_t              ent_q [DEPTH];
   entry_t              ent_d [DEPTH];
   logic [PC_WIDTH-1:0] pc_q [DEPTH];
   logic [PC_WIDTH-1:0] pc_d [DEPTH];
   logic [AW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [AW:0]         count_q, count_d;
   logic [1:0]          out_valid_q, out_valid_d;
   logic                dual_ok_q, dual_ok_d;
   logic [1:0]          wr_n, pop_n;
   logic [3:0]          cls0_w, cls1_w;
   logic [4:0]          dest0_w, dest1_w;
   entry_t              nh0, nh1;
   logic                hazard;

   pre_decode_slot u_slot0 (.instr(in_instr0), .cls(cls0_w), .dest(dest0_w));
   pre_decode_slot u_slot1 (.instr(in_instr1), .cls(cls1_w), .dest(dest1_w));

   // readiness looks only at the registered occupancy
   assign in_ready = (count_q <= RDY_MAX);

   // accepted writes / pops; 10 patterns and over-acks are ignored
   always_comb begin
      wr_n = 2'd0;
      if (in_ready && in_valid == 2'b01) wr_n = 2'd1;
      if (in_ready && in_valid == 2'b11) wr_n = 2'd2;
      pop_n = 2'd0;
      if (issue_ack == 2'b01 && out_valid_q[0]) pop_n = 2'd1;
      if (issue_ack == 2'b11 && dual_ok_q)      pop_n = 2'd2;
   end

   // next buffer contents and pointers; flush wins over writes and pops
   always_comb begin
      ent_d   = ent_q;
      pc_d    = pc_q;
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q + AW'(wr_n);
      count_d = count_q + (AW+1)'(wr_n) - (AW+1)'(pop_n);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (wr_n != 2'd0) begin
            ent_d[tail_q] = '{instr: in_instr0, cls: cls0_w, dest: dest0_w};
            pc_d[tail_q]  = in_pc0;
         end
         if (wr_n == 2'd2) begin
            ent_d[tail_q + AW'(1)] = '{instr: in_instr1, cls: cls1_w, dest: dest1_w};
            pc_d[tail_q + AW'(1)]  = in_pc1;
         end
      end
   end

   // issue flags for the next cycle, evaluated on the next-state head pair
   always_comb begin
      nh0 = ent_d[head_d];
      nh1 = ent_d[head_d + AW'(1)];
      out_valid_d[0] = (count_d != '0) &&
                       !(nh0.cls[CLS_BRANCH] && count_d == (AW+1)'(1));
      out_valid_d[1] = out_valid_d[0] && (count_d > (AW+1)'(1));
      hazard = nh0.cls[CLS_TRAP] || nh1.cls[CLS_TRAP] || nh1.cls[CLS_BRANCH] ||
               (nh0.cls[CLS_HILO] && nh1.cls[CLS_HILO]) ||
               ((nh0.dest != 5'd0) &&
                ((nh0.dest == nh1.instr[25:21]) || (nh0.dest == nh1.instr[20:16])));
      dual_ok_d = out_valid_d[1] && (nh0.cls[CLS_BRANCH] || !hazard);
   end

   // state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            pc_q[i]  <= '0;
         end
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         out_valid_q <= '0;
         dual_ok_q   <= 1'b0;
      end else begin
         ent_q       <= ent_d;
         pc_q        <= pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         dual_ok_q   <= dual_ok_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign dual_ok    = dual_ok_q;
   assign out_instr0 = ent_q[head_q].instr;
   assign out_instr1 = ent_q[head_q + AW'(1)].instr;
   assign out_class0 = ent_q[head_q].cls;
   assign out_class1 = ent_q[head_q + AW'(1)].cls;
   assign out_pc0    = pc_q[head_q];
   assign out_pc1    = pc_q[head_q + AW'(1)];

`ifdef PRE_DECODE_PERF_CNT_EN
   logic [31:0] perf_single_q, perf_single_d, perf_dual_q, perf_dual_d;

   // count accepted single/dual issue cycles; flushed cycles do not count
   always_comb begin
      perf_single_d = perf_single_q;
      perf_dual_d   = perf_dual_q;
      if (!flush && pop_n == 2'd1) perf_single_d = perf_single_q + 32'd1;
      if (!flush && pop_n == 2'd2) perf_dual_d   = perf_dual_q + 32'd1;
   end

   // counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_single_q <= '0;
         perf_dual_q   <= '0;
      end else begin
         perf_single_q <= perf_single_d;
         perf_dual_q   <= perf_dual_d;
      end
   end

   assign perf_single = perf_single_q;
   assign perf_dual   = perf_dual_q;
`else
   assign perf_single = '0;
   assign perf_dual   = '0;
`endif
endmodule

// File: tb/tb_pre_decode_issue_buffer.sv
// Randomized bench for pre_decode_issue_buffer against a queue-based model.
module tb_pre_decode_issue_buffer;
   localparam int DEPTH = 8;
   localparam int PW    = 32;

   logic          clk = 1'b0;
   logic          rst, flush;
   logic [1:0]    in_valid, issue_ack;
   logic [31:0]   in_instr0, in_instr1;
   logic [PW-1:0] in_pc0, in_pc1;
   logic          in_ready, dual_ok;
   logic [1:0]    out_valid;
   logic [31:0]   out_instr0, out_instr1, perf_single, perf_dual;
   logic [PW-1:0] out_pc0, out_pc1;
   logic [3:0]    out_class0, out_class1;

   pre_decode_issue_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
      .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc0(in_pc0), .in_pc1(in_pc1),
      .in_ready(in_ready), .out_valid(out_valid), .out_instr0(out_instr0),
      .out_instr1(out_instr1), .out_pc0(out_pc0), .out_pc1(out_pc1),
      .out_class0(out_class0), .out_class1(out_class1), .dual_ok(dual_ok),
      .issue_ack(issue_ack), .perf_single(perf_single), .perf_dual(perf_dual)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference model: program-order queue plus counters
   logic [31:0]   mq_i[$];
   logic [PW-1:0] mq_pc[$];
   logic [31:0]   m_ps = 0, m_pd = 0;
   logic [PW-1:0] pc_ctr = 32'h1000;

   function automatic bit m_br(input logic [31:0] x);
      int op, f;
      op = int'(x[31:26]); f = int'(x[5:0]);
      return (op >= 1 && op <= 7) || (op == 0 && (f == 8 || f == 9));
   endfunction
   function automatic bit m_tp(input logic [31:0] x);
      int op, f, rs;
      op = int'(x[31:26]); f = int'(x[5:0]); rs = int'(x[25:21]);
      return (op == 0 && (f == 12 || f == 13)) || (op == 16 && (f == 24 || rs == 0 || rs == 4));
   endfunction
   function automatic bit m_hl(input logic [31:0] x);
      int op, f;
      op = int'(x[31:26]); f = int'(x[5:0]);
      return op == 0 && ((f >= 16 && f <= 19) || (f >= 24 && f <= 27));
   endfunction
   function automatic int m_dst(input logic [31:0] x);
      int op;
      op = int'(x[31:26]);
      if (op == 0) return int'(x[15:11]);
      if (op == 3) return 31;
      if ((op >= 8 && op <= 15) || (op >= 32 && op <= 39)) return int'(x[20:16]);
      return 0;
   endfunction
   function automatic logic [3:0] m_cls(input logic [31:0] x);
      return {x == 32'd0, m_hl(x), m_tp(x), m_br(x)};
   endfunction

   // compare every output against the model; return the model's issue flags
   task automatic check_outputs(output bit ov0, output bit dok);
      int n, d;
      bit ov1, hz;
      n = mq_i.size();
      ov0 = (n >= 1) && !(n == 1 && m_br(mq_i[0]));
      ov1 = ov0 && n >= 2;
      dok = 1'b0;
      if (ov1) begin
         d  = m_dst(mq_i[0]);
         hz = m_tp(mq_i[0]) || m_tp(mq_i[1]) || m_br(mq_i[1]) ||
              (m_hl(mq_i[0]) && m_hl(mq_i[1])) ||
              (d != 0 && (d == int'(mq_i[1][25:21]) || d == int'(mq_i[1][20:16])));
         dok = m_br(mq_i[0]) || !hz;
      end
      chk("in_ready", 64'(in_ready), 64'((DEPTH - n) >= 2));
      chk("out_valid", 64'(out_valid), 64'({ov1, ov0}));
      chk("dual_ok", 64'(dual_ok), 64'(dok));
      if (n >= 1) begin
         chk("out_instr0", 64'(out_instr0), 64'(mq_i[0]));
         chk("out_pc0", 64'(out_pc0), 64'(mq_pc[0]));
         chk("out_class0", 64'(out_class0), 64'(m_cls(mq_i[0])));
      end
      if (n >= 2) begin
         chk("out_instr1", 64'(out_instr1), 64'(mq_i[1]));
         chk("out_pc1", 64'(out_pc1), 64'(mq_pc[1]));
         chk("out_class1", 64'(out_class1), 64'(m_cls(mq_i[1])));
      end
`ifdef PRE_DECODE_PERF_CNT_EN
      chk("perf_single", 64'(perf_single), 64'(m_ps));
      chk("perf_dual", 64'(perf_dual), 64'(m_pd));
`else
      chk("perf_single", 64'(perf_single), 64'd0);
      chk("perf_dual", 64'(perf_dual), 64'd0);
`endif
   endtask

   // one clock: drive, check current outputs, advance model, step past edge
   task automatic cyc(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] ack, input logic fl);
      bit ov0, dok, rdy;
      logic [1:0] a;
      #3;
      check_outputs(ov0, dok);
      a = ack;
      if (a == 2'b11 && !dok) a = 2'b01;   // never issue an illegal pair
      in_valid = v; in_instr0 = i0; in_instr1 = i1;
      in_pc0 = pc_ctr; in_pc1 = pc_ctr + 4; issue_ack = a; flush = fl;
      rdy = (DEPTH - mq_i.size()) >= 2;
      if (fl) begin
         mq_i.delete(); mq_pc.delete();
      end else begin
         if (a == 2'b01 && ov0) begin
            void'(mq_i.pop_front()); void'(mq_pc.pop_front()); m_ps++;
         end else if (a == 2'b11 && dok) begin
            repeat (2) begin void'(mq_i.pop_front()); void'(mq_pc.pop_front()); end
            m_pd++;
         end
         if (rdy && v[0]) begin mq_i.push_back(i0); mq_pc.push_back(pc_ctr); end
         if (rdy && v == 2'b11) begin mq_i.push_back(i1); mq_pc.push_back(pc_ctr + 4); end
      end
      pc_ctr += 8;
      @(posedge clk); #1;
      in_valid = 2'b00; issue_ack = 2'b00; flush = 1'b0;
   endtask

   function automatic logic [31:0] pick_instr();
      logic [31:0] pool [14];
      pool = '{32'h00000000, 32'h02114020, 32'h01124822, 32'h10000003, 32'h0C000010,
               32'h03E00008, 32'h0000000C, 32'h02110018, 32'h00004012, 32'h42000018,
               32'h40086000, 32'h24080001, 32'h8D090000, 32'h34020001};
      if ($urandom_range(0, 4) == 0) return $urandom;
      return pool[$urandom_range(0, 13)];
   endfunction

   localparam logic [31:0] ADD = 32'h02114020, SUB = 32'h01124822, BEQ = 32'h10000003;

   initial begin
      bit ov0, dok;
      logic [31:0] a, b;
      rst = 1'b1; flush = 1'b0; in_valid = 2'b00; issue_ack = 2'b00;
      in_instr0 = '0; in_instr1 = '0; in_pc0 = '0; in_pc1 = '0;
      #12;
      check_outputs(ov0, dok);
      chk("rst_instr0", 64'(out_instr0), 64'd0);
      chk("rst_pc0", 64'(out_pc0), 64'd0);
      chk("rst_class0", 64'(out_class0), 64'd0);
      chk("rst_instr1", 64'(out_instr1), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // nop + add pair
      cyc(2'b11, 32'h0, ADD, 2'b00, 1'b0);
      chk("nop_class", 64'(out_class0), 64'h8);
      chk("nop_add_dual", 64'(dual_ok), 64'd1);
      cyc(2'b00, 0, 0, 2'b11, 1'b0);
      // branch waits for its delay slot, then pairs
      cyc(2'b01, BEQ, 0, 2'b00, 1'b0);
      chk("beq_alone", 64'(out_valid), 64'd0);
      cyc(2'b01, ADD, 0, 2'b00, 1'b0);
      chk("beq_pair", 64'({out_valid, dual_ok}), 64'b111);
      cyc(2'b00, 0, 0, 2'b11, 1'b0);
      chk("beq_drained", 64'({out_valid, in_ready}), 64'b001);
      // RAW hazard
      cyc(2'b11, ADD, SUB, 2'b00, 1'b0);
      chk("raw_dual", 64'(dual_ok), 64'd0);
      cyc(2'b00, 0, 0, 2'b01, 1'b0);
      chk("raw_head", 64'(out_instr0), 64'(SUB));
      cyc(2'b00, 0, 0, 2'b01, 1'b0);
      // hilo pair, then syscall head
      cyc(2'b11, 32'h02110018, 32'h00004012, 2'b00, 1'b0);
      chk("hilo_dual", 64'(dual_ok), 64'd0);
      cyc(2'b00, 0, 0, 2'b01, 1'b0);
      cyc(2'b00, 0, 0, 2'b01, 1'b0);
      cyc(2'b11, 32'h0000000C, 32'h34020001, 2'b00, 1'b0);
      chk("sys_dual", 64'(dual_ok), 64'd0);
      cyc(2'b00, 0, 0, 2'b01, 1'b0);
      cyc(2'b00, 0, 0, 2'b01, 1'b0);
      // fill to DEPTH-1 with independent ORIs, then pop/write across wrap
      for (int k = 0; k < 3; k++)
         cyc(2'b11, 32'h34000000 | ((2*k+1) << 16), 32'h34000000 | ((2*k+2) << 16), 2'b00, 1'b0);
      cyc(2'b01, 32'h34070000, 0, 2'b00, 1'b0);
      chk("full_ready", 64'(in_ready), 64'd0);
      cyc(2'b11, 32'h34080000, 32'h34090000, 2'b00, 1'b0);   // dropped
      cyc(2'b11, 32'h340A0000, 32'h340B0000, 2'b11, 1'b0);   // still dropped
      cyc(2'b11, 32'h340C0000, 32'h340D0000, 2'b11, 1'b0);   // wraps
      for (int k = 0; k < 4; k++) cyc(2'b00, 0, 0, 2'b11, 1'b0);
      // flush beats simultaneous write and ack
      cyc(2'b11, ADD, ADD, 2'b00, 1'b0);
      cyc(2'b11, ADD, SUB, 2'b01, 1'b1);
      chk("flush_state", 64'({out_valid, in_ready}), 64'b001);

      // randomized traffic
      for (int t = 0; t < 3000; t++) begin
         a = pick_instr(); b = pick_instr();
         cyc(2'($urandom_range(0, 3)), a, b, 2'($urandom_range(0, 3)),
             ($urandom_range(0, 40) == 0));
      end

      // asynchronous reset between edges
      cyc(2'b11, ADD, 32'h34020001, 2'b00, 1'b0);
      #2; rst = 1'b1; #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_ready", 64'(in_ready), 64'd1);
      chk("arst_instr0", 64'(out_instr0), 64'd0);
      chk("arst_perf", 64'({perf_single, perf_dual}), 64'd0);
      mq_i.delete(); mq_pc.delete(); m_ps = 0; m_pd = 0;
      @(posedge clk); #1; rst = 1'b0;
      cyc(2'b11, ADD, 32'h34020001, 2'b00, 1'b0);
      cyc(2'b00, 0, 0, 2'b11, 1'b0);
      cyc(2'b00, 0, 0, 2'b00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
